// File: rtl/alu_exec_stage.sv
// Integer ALU execute stage: 1-cycle registered result toward the CDB,
// with an output register plus a skid register so CDB stalls cost no issue bandwidth.

package alu_pkg;
    typedef enum logic [3:0] {
        noALU    = 4'd0,
        addALU   = 4'd1,
        subALU   = 4'd2,
        xorALU   = 4'd3,
        orALU    = 4'd4,
        andALU   = 4'd5,
        sllALU   = 4'd6,
        srlALU   = 4'd7,
        sraALU   = 4'd8,
        sltALU   = 4'd9,
        sltuALU  = 4'd10,
        luiALU   = 4'd11,
        auipcALU = 4'd12
    } ALU_operation_t;
endpackage

// state | meaning
// EMPTY | nothing held, cdb_valid=0
// ONE   | output register holds a result, skid empty
// TWO   | output register and skid both hold results (skid is younger), in_ready=0
module alu_exec_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             cdb_valid,
    input  logic             cdb_ready,
    output logic [XLEN-1:0]  cdb_result,
    output logic             cdb_zero,
    output logic [TAG_W-1:0] cdb_tag
);
    import alu_pkg::*;

    localparam int SH_W = $clog2(XLEN);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

    occ_e             state_q, state_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [XLEN-1:0]  skid_result_q, skid_result_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             in_ready_q, in_ready_d;

    logic [XLEN-1:0]  alu_result;
    logic [SH_W-1:0]  shamt;
    logic             accept;
    logic             drain;

    assign shamt = in_b[SH_W-1:0];

    always_comb begin
        alu_result = '0;
        case (in_op)
            addALU:   alu_result = in_a + in_b;
            subALU:   alu_result = in_a - in_b;
            xorALU:   alu_result = in_a ^ in_b;
            orALU:    alu_result = in_a | in_b;
            andALU:   alu_result = in_a & in_b;
            sllALU:   alu_result = in_a << shamt;
            srlALU:   alu_result = in_a >> shamt;
            sraALU:   alu_result = $unsigned($signed(in_a) >>> shamt);
            sltALU:   alu_result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            sltuALU:  alu_result = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            luiALU:   alu_result = in_b;
            auipcALU: alu_result = in_pc + in_b;
            default:  alu_result = '0;
        endcase
    end

    assign accept = in_valid && in_ready_q;
    assign drain  = (state_q != EMPTY) && cdb_ready;

    always_comb begin
        state_d       = state_q;
        out_result_d  = out_result_q;
        out_tag_d     = out_tag_q;
        skid_result_d = skid_result_q;
        skid_tag_d    = skid_tag_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_result_d = alu_result;
                    out_tag_d    = in_tag;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    out_result_d = alu_result;
                    out_tag_d    = in_tag;
                end else if (accept) begin
                    skid_result_d = alu_result;
                    skid_tag_d    = in_tag;
                    state_d       = TWO;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // skid is the older pending entry once the output register drains
                if (drain) begin
                    out_result_d = skid_result_q;
                    out_tag_d    = skid_tag_q;
                    state_d      = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= EMPTY;
            out_result_q  <= '0;
            out_tag_q     <= '0;
            skid_result_q <= '0;
            skid_tag_q    <= '0;
            in_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            out_result_q  <= out_result_d;
            out_tag_q     <= out_tag_d;
            skid_result_q <= skid_result_d;
            skid_tag_q    <= skid_tag_d;
            in_ready_q    <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign cdb_valid  = (state_q != EMPTY);
    assign cdb_result = out_result_q;
    assign cdb_tag    = out_tag_q;
    // gated by valid so the idle/reset value reads 0 rather than "result is zero"
    assign cdb_zero   = cdb_valid && (out_result_q == '0);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed cases plus randomized traffic checked against
// a queue-based model of the stage (results in flight, at most two held).

module tb_alu_exec_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, cdb_valid, cdb_ready, cdb_zero;
    logic [3:0]  in_op;
    logic [31:0] in_a, in_b, in_pc, cdb_result;
    logic [5:0]  in_tag, cdb_tag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  tag;
    } entry_t;

    entry_t held[$];

    alu_exec_stage #(.XLEN(32), .TAG_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_pc      (in_pc),
        .in_tag     (in_tag),
        .cdb_valid  (cdb_valid),
        .cdb_ready  (cdb_ready),
        .cdb_result (cdb_result),
        .cdb_zero   (cdb_zero),
        .cdb_tag    (cdb_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] pc);
        int unsigned sh;
        longint      sa;
        sh = b % 32;
        sa = longint'(signed'(a));
        case (op)
            addALU:   return a + b;
            subALU:   return a - b;
            xorALU:   return a ^ b;
            orALU:    return a | b;
            andALU:   return a & b;
            sllALU:   return a * (32'd1 << sh);
            srlALU:   return a / (32'd1 << sh);
            sraALU:   return 32'(sa >>> sh);
            sltALU:   return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            sltuALU:  return (a < b) ? 32'd1 : 32'd0;
            luiALU:   return b;
            auipcALU: return pc + b;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic check_outputs(input bit after_reset);
        chk("cdb_valid", cdb_valid, held.size() > 0);
        chk("in_ready", in_ready, held.size() < 2);
        if (held.size() > 0) begin
            chk("cdb_result", cdb_result, held[0].res);
            chk("cdb_tag", cdb_tag, held[0].tag);
            chk("cdb_zero", cdb_zero, held[0].res == 32'd0);
        end else begin
            chk("cdb_zero_idle", cdb_zero, 0);
        end
        if (after_reset) begin
            chk("rst_result", cdb_result, 0);
            chk("rst_tag", cdb_tag, 0);
        end
    endtask

    // One clock: drive at negedge, update the model, check at the following negedge.
    task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic [5:0] tg,
                        input logic rdy, input logic fl, input logic rst);
        bit     can_take;
        entry_t e;
        reset = rst; flush = fl; in_valid = v; in_op = op;
        in_a = a; in_b = b; in_pc = pc; in_tag = tg; cdb_ready = rdy;
        can_take = held.size() < 2;
        if (rst) begin
            held.delete();
        end else begin
            if (held.size() > 0 && rdy) void'(held.pop_front());
            if (fl) begin
                held.delete();
            end else if (v && can_take) begin
                e.res = ref_alu(op, a, b, pc);
                e.tag = tg;
                held.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs(rst);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 6'd0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 4'd0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b1, addALU, 5, 5, 0, 7, 1'b0, 1'b1, 1'b1);
        chk("rst_valid", cdb_valid, 0);
        chk("rst_ready", in_ready, 1);

        // basic arithmetic
        step(1'b1, addALU, 32'hFFFF_FFFF, 32'd1, 0, 6'd3, 1'b1, 1'b0, 1'b0);
        chk("t1_result", cdb_result, 0);
        chk("t1_zero", cdb_zero, 1);
        chk("t1_tag", cdb_tag, 3);
        step(1'b1, sraALU, 32'h8000_0000, 32'h24, 0, 6'd4, 1'b1, 1'b0, 1'b0);
        chk("t2_sra", cdb_result, 32'hF800_0000);
        step(1'b1, srlALU, 32'h8000_0000, 32'h24, 0, 6'd5, 1'b1, 1'b0, 1'b0);
        chk("t2_srl", cdb_result, 32'h0800_0000);
        step(1'b1, sltALU, 32'hFFFF_FFFF, 32'd1, 0, 6'd6, 1'b1, 1'b0, 1'b0);
        chk("t3_slt", cdb_result, 1);
        step(1'b1, sltuALU, 32'hFFFF_FFFF, 32'd1, 0, 6'd7, 1'b1, 1'b0, 1'b0);
        chk("t3_sltu", cdb_result, 0);
        step(1'b1, auipcALU, 32'd0, 32'h2000, 32'h1000, 6'd8, 1'b1, 1'b0, 1'b0);
        chk("t3_auipc", cdb_result, 32'h3000);
        step(1'b1, luiALU, 32'h1234, 32'hABCD_E000, 0, 6'd9, 1'b1, 1'b0, 1'b0);
        chk("t3_lui", cdb_result, 32'hABCD_E000);
        step(1'b1, 4'd14, 32'h55, 32'h66, 0, 6'd10, 1'b1, 1'b0, 1'b0);
        chk("unlisted_op", cdb_result, 0);
        chk("unlisted_tag", cdb_tag, 10);
        idle(1'b1);

        // backpressure: two held, no loss, order kept
        step(1'b1, addALU, 1, 1, 0, 6'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, addALU, 2, 2, 0, 6'd2, 1'b0, 1'b0, 1'b0);
        chk("bp_ready_low", in_ready, 0);
        step(1'b1, addALU, 3, 3, 0, 6'd33, 1'b0, 1'b0, 1'b0);
        chk("bp_head_tag", cdb_tag, 1);
        step(1'b0, 4'd0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("bp_second_tag", cdb_tag, 2);
        idle(1'b1);
        chk("bp_drained", cdb_valid, 0);

        // flush with both entries held, then flush while an op is accepted
        step(1'b1, orALU, 4, 8, 0, 6'd11, 1'b0, 1'b0, 1'b0);
        step(1'b1, orALU, 4, 9, 0, 6'd12, 1'b0, 1'b0, 1'b0);
        step(1'b1, xorALU, 1, 2, 0, 6'd9, 1'b0, 1'b1, 1'b0);
        chk("fl_valid", cdb_valid, 0);
        chk("fl_ready", in_ready, 1);
        step(1'b1, andALU, 7, 3, 0, 6'd13, 1'b1, 1'b0, 1'b0);
        step(1'b1, xorALU, 1, 2, 0, 6'd9, 1'b1, 1'b1, 1'b0);
        chk("fl_discard", cdb_valid, 0);
        idle(1'b1);

        // streaming, then reset mid-stream with a stall in progress
        for (int i = 0; i < 16; i++)
            step(1'b1, subALU, 32'(i * 3), 32'(i), 0, 6'(20 + i), 1'b1, 1'b0, 1'b0);
        step(1'b1, addALU, 9, 9, 0, 6'd40, 1'b0, 1'b0, 1'b0);
        step(1'b1, addALU, 9, 9, 0, 6'd41, 1'b0, 1'b0, 1'b0);
        step(1'b1, addALU, 9, 9, 0, 6'd42, 1'b0, 1'b1, 1'b1);
        chk("mid_rst_valid", cdb_valid, 0);
        chk("mid_rst_zero", cdb_zero, 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), $urandom(),
                 ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(), $urandom(),
                 6'($urandom_range(0, 63)), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
